mem_stage: RTL and testbench

Memory-access pipeline stage sitting between the execute stage and the write-back stage. It accepts one instruction at a time from execute and holds any load or store until the data-memory response handshake completes. It sign- or zero-extends load data and forwards the result to write-back over the `ms_to_ws` valid/allowin interface. It also drives the forwarding/hazard bus back to decode.

---
 rtl/mem_stage_if.sv | 51 +++++
 rtl/mem_stage.sv | 161 ++++++++++++++++
 tb/tb_mem_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle around the memory-access stage: execute-side
// input, write-back-side output, data-memory response and the
// forwarding/hazard bus back to decode.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 75
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

interface mem_stage_if;
  // execute -> mem
  logic                          ms_allowin;
  logic                          es_to_ms_valid;
  logic [`ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
  // mem -> write-back
  logic                          ms_to_ws_valid;
  logic [`MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
  logic                          ws_allowin;
  // data-memory response
  logic                          data_sram_data_ok;
  logic [31:0]                   data_sram_rdata;
  // mem -> decode forwarding/hazard
  logic [37:0]                   ms_to_ds_bus;

  // The stage itself.
  modport slave (
    output ms_allowin,
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    output ms_to_ws_valid,
    output ms_to_ws_bus,
    input  ws_allowin,
    input  data_sram_data_ok,
    input  data_sram_rdata,
    output ms_to_ds_bus
  );

  // The surrounding pipeline / memory system.
  modport master (
    input  ms_allowin,
    output es_to_ms_valid,
    output es_to_ms_bus,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus,
    output ws_allowin,
    output data_sram_data_ok,
    output data_sram_rdata,
    input  ms_to_ds_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the
// data-memory response of a load/store, extends load data and hands the
// result to write-back. Also publishes the forwarding/hazard view to decode.
`ifndef ES_TO_MS_BUS_WD
`define ES_TO_MS_BUS_WD 75
`endif
`ifndef MS_TO_WS_BUS_WD
`define MS_TO_WS_BUS_WD 70
`endif

module mem_stage (
  input  logic          clk,
  input  logic          reset,
  mem_stage_if.slave    bus_if
);

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_B  = 3'b001;
  localparam logic [2:0] LD_H  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  // Select and extend the loaded byte/half/word; unknown types act as a word load.
  function automatic logic [31:0] load_extend(input logic [2:0]  ld_type,
                                              input logic [1:0]  addr_lo,
                                              input logic [31:0] word);
    logic [7:0]  byte_sel_s;
    logic [15:0] half_sel_s;
    logic [31:0] res_s;
    case (addr_lo)
      2'd0:    byte_sel_s = word[7:0];
      2'd1:    byte_sel_s = word[15:8];
      2'd2:    byte_sel_s = word[23:16];
      2'd3:    byte_sel_s = word[31:24];
      default: byte_sel_s = word[7:0];
    endcase
    if (addr_lo[1]) begin
      half_sel_s = word[31:16];
    end else begin
      half_sel_s = word[15:0];
    end
    case (ld_type)
      LD_W:    res_s = word;
      LD_B:    res_s = {{24{byte_sel_s[7]}}, byte_sel_s};
      LD_BU:   res_s = {24'h00_0000, byte_sel_s};
      LD_H:    res_s = {{16{half_sel_s[15]}}, half_sel_s};
      LD_HU:   res_s = {16'h0000, half_sel_s};
      default: res_s = word;
    endcase
    return res_s;
  endfunction

  // State
  logic                        ms_valid_r;
  logic [`ES_TO_MS_BUS_WD-1:0] es_bus_r;
  logic                        resp_got_r;
  logic [31:0]                 resp_buf_r;

  // Fields of the held instruction
  logic        res_from_mem_s;
  logic [2:0]  ld_type_s;
  logic        req_issued_s;
  logic        gr_we_s;
  logic [4:0]  dest_s;
  logic [31:0] alu_result_s;
  logic [31:0] pc_s;

  assign res_from_mem_s = es_bus_r[74];
  assign ld_type_s      = es_bus_r[73:71];
  assign req_issued_s   = es_bus_r[70];
  assign gr_we_s        = es_bus_r[69];
  assign dest_s         = es_bus_r[68:64];
  assign alu_result_s   = es_bus_r[63:32];
  assign pc_s           = es_bus_r[31:0];

  // Derived control/data
  logic        ms_ready_go_s;
  logic        ms_allowin_s;
  logic        ms_to_ws_valid_s;
  logic        ms_leave_s;
  logic        ms_load_s;
  logic        resp_capture_s;
  logic [31:0] eff_rdata_s;
  logic [31:0] final_result_s;
  logic [4:0]  fwd_dest_s;
  logic        load_pending_s;

  // Handshake, response capture condition and result selection.
  always_comb begin
    ms_ready_go_s    = !req_issued_s || resp_got_r || bus_if.data_sram_data_ok;
    ms_allowin_s     = !ms_valid_r || (ms_ready_go_s && bus_if.ws_allowin);
    ms_to_ws_valid_s = ms_valid_r && ms_ready_go_s;
    ms_leave_s       = ms_to_ws_valid_s && bus_if.ws_allowin;
    ms_load_s        = bus_if.es_to_ms_valid && ms_allowin_s;
    // Only the first data_ok for the held request is captured; a stray
    // data_ok without a request in this stage is ignored.
    resp_capture_s   = ms_valid_r && req_issued_s && !resp_got_r && bus_if.data_sram_data_ok;

    if (resp_got_r) begin
      eff_rdata_s = resp_buf_r;
    end else begin
      eff_rdata_s = bus_if.data_sram_rdata;
    end

    if (res_from_mem_s) begin
      final_result_s = load_extend(ld_type_s, alu_result_s[1:0], eff_rdata_s);
    end else begin
      final_result_s = alu_result_s;
    end

    if (ms_valid_r && gr_we_s) begin
      fwd_dest_s = dest_s;
    end else begin
      fwd_dest_s = 5'd0;
    end

    load_pending_s = ms_valid_r && res_from_mem_s && !ms_ready_go_s;
  end

  // Stage occupancy: follows the upstream offer whenever the stage can accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid_r <= 1'b0;
    end else if (ms_allowin_s) begin
      ms_valid_r <= bus_if.es_to_ms_valid;
    end
  end

  // Instruction register: captured on acceptance only, never reset.
  always_ff @(posedge clk) begin
    if (ms_load_s) begin
      es_bus_r <= bus_if.es_to_ms_bus;
    end
  end

  // Response-received flag: leaving or a new instruction wins over capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_got_r <= 1'b0;
    end else if (ms_leave_s || ms_load_s) begin
      resp_got_r <= 1'b0;
    end else if (resp_capture_s) begin
      resp_got_r <= 1'b1;
    end
  end

  // Response data buffer: keeps load data stable across write-back stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_buf_r <= 32'h0000_0000;
    end else if (resp_capture_s) begin
      resp_buf_r <= bus_if.data_sram_rdata;
    end
  end

  assign bus_if.ms_allowin     = ms_allowin_s;
  assign bus_if.ms_to_ws_valid = ms_to_ws_valid_s;
  assign bus_if.ms_to_ws_bus   = {gr_we_s, dest_s, final_result_s, pc_s};
  assign bus_if.ms_to_ds_bus   = {load_pending_s, fwd_dest_s, final_result_s};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases followed by randomized
// traffic, with a per-cycle handshake model and a scoreboard on handoffs.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_stage_if bus_if();

  mem_stage u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_if (bus_if)
  );

  typedef struct {
    logic        rfm;
    logic [2:0]  lt;
    logic        req;
    logic        we;
    logic [4:0]  dest;
    logic [31:0] alu;
    logic [31:0] pc;
    int          delay;
    int          stall;
    logic [31:0] rdata;
  } instr_t;

  instr_t      pend_q[$];
  logic [69:0] sb_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // model of what the stage currently holds
  bit          occ, occ_mem, occ_load, occ_resp, occ_we;
  logic [4:0]  occ_dest;
  logic [31:0] occ_res;
  // upstream / responder / downstream state
  bit          offer;
  bit          resp_pend;
  int          resp_cnt;
  logic [31:0] resp_data;
  int          resp_stall;
  int          stall_left;
  bit          rst_req;
  bit          random_mode;
  logic [31:0] pc_ctr;

  function automatic logic [74:0] pack_bus(instr_t t);
    return {t.rfm, t.lt, t.req, t.we, t.dest, t.alu, t.pc};
  endfunction

  // Expected final_result from the instruction's semantics.
  function automatic logic [31:0] model_result(instr_t t);
    logic [31:0] v;
    if (!t.rfm) return t.alu;
    case (t.lt)
      3'd1, 3'd3: begin
        v = (t.rdata >> (32'd8 * 32'(t.alu[1:0]))) & 32'h0000_00FF;
        if (t.lt == 3'd1 && v > 32'd127) v = v - 32'd256;
        return v;
      end
      3'd2, 3'd4: begin
        v = (t.rdata >> (32'd16 * 32'(t.alu[1]))) & 32'h0000_FFFF;
        if (t.lt == 3'd2 && v > 32'd32767) v = v - 32'd65536;
        return v;
      end
      default: return t.rdata;
    endcase
  endfunction

  function automatic instr_t mk(bit rfm, logic [2:0] lt, bit req, bit we,
                                logic [4:0] dest, logic [31:0] alu,
                                int delay, int stall, logic [31:0] rdata);
    instr_t t;
    t.rfm = rfm; t.lt = lt; t.req = req; t.we = we; t.dest = dest;
    t.alu = alu; t.pc = 32'h0; t.delay = delay; t.stall = stall; t.rdata = rdata;
    return t;
  endfunction

  task automatic push(instr_t t);
    t.pc = pc_ctr;
    pc_ctr = pc_ctr + 32'd4;
    pend_q.push_back(t);
  endtask

  task automatic chk(string name, logic [69:0] act, logic [69:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check just before posedge,
  // then advance the model to what the posedge will do.
  task automatic step();
    instr_t     cur;
    bit         dok, e_ready, e_tows, e_allow, e_pend, leaving, accepted;
    logic [4:0] e_fwd;
    @(negedge clk);
    #1;
    reset = rst_req;
    if (resp_pend && resp_cnt == 0 && !rst_req) begin
      bus_if.data_sram_data_ok = 1'b1;
      bus_if.data_sram_rdata   = resp_data;
    end else begin
      bus_if.data_sram_data_ok = 1'b0;
      bus_if.data_sram_rdata   = random_mode ? $urandom : 32'h0;
      if (resp_pend && resp_cnt > 0) resp_cnt--;
    end
    if (bus_if.data_sram_data_ok && resp_stall > 0) begin
      bus_if.ws_allowin = 1'b0;
      stall_left = resp_stall - 1;
    end else if (stall_left > 0) begin
      bus_if.ws_allowin = 1'b0;
      stall_left--;
    end else if (random_mode) begin
      bus_if.ws_allowin = ($urandom_range(0, 3) != 0);
    end else begin
      bus_if.ws_allowin = 1'b1;
    end
    if (!offer && pend_q.size() > 0 && !rst_req && (!random_mode || $urandom_range(0, 2) != 0))
      offer = 1'b1;
    bus_if.es_to_ms_valid = offer;
    if (offer) bus_if.es_to_ms_bus = pack_bus(pend_q[0]);
    else       bus_if.es_to_ms_bus = {11'($urandom), $urandom, $urandom};
    #3;
    if (rst_req) begin
      occ = 1'b0; occ_resp = 1'b0; resp_pend = 1'b0; stall_left = 0;
      sb_q.delete();
      return;
    end
    dok = bus_if.data_sram_data_ok;
    if (dok) assert (occ && occ_mem && !occ_resp)
      else $error("data_ok with no outstanding request in the stage");
    e_ready = !occ_mem || occ_resp || dok;
    e_tows  = occ && e_ready;
    e_allow = !occ || (e_ready && bus_if.ws_allowin);
    e_fwd   = (occ && occ_we) ? occ_dest : 5'd0;
    e_pend  = occ && occ_load && !e_ready;
    chk("ms_to_ws_valid", 70'(bus_if.ms_to_ws_valid), 70'(e_tows));
    chk("ms_allowin", 70'(bus_if.ms_allowin), 70'(e_allow));
    chk("ms_fwd_dest", 70'(bus_if.ms_to_ds_bus[36:32]), 70'(e_fwd));
    chk("ms_load_pending", 70'(bus_if.ms_to_ds_bus[37]), 70'(e_pend));
    if (e_tows) chk("ds_final_result", 70'(bus_if.ms_to_ds_bus[31:0]), 70'(occ_res));
    leaving  = e_tows && bus_if.ws_allowin;
    accepted = offer && e_allow;
    if (dok) begin
      resp_pend = 1'b0;
      if (occ) occ_resp = 1'b1;
    end
    if (leaving) occ = 1'b0;
    if (accepted) begin
      cur      = pend_q.pop_front();
      offer    = 1'b0;
      occ      = 1'b1;
      occ_mem  = cur.req;
      occ_load = cur.rfm;
      occ_we   = cur.we;
      occ_dest = cur.dest;
      occ_resp = 1'b0;
      occ_res  = model_result(cur);
      sb_q.push_back({cur.we, cur.dest, occ_res, cur.pc});
      resp_stall = cur.stall;
      if (cur.req) begin
        resp_pend = 1'b1;
        resp_cnt  = cur.delay;
        resp_data = cur.rdata;
      end
    end
  endtask

  task automatic run_until_idle(int budget);
    int i;
    for (i = 0; i < budget && (pend_q.size() > 0 || occ || offer); i++) step();
    if (pend_q.size() > 0 || occ || offer) begin
      n_tests++; n_fail++;
      $display("FAIL timeout: %0d instructions still queued after %0d cycles", pend_q.size(), budget);
    end
  endtask

  // Scoreboard monitor: compare every write-back handoff against the queue.
  initial begin
    logic [69:0] exp;
    forever begin
      @(negedge clk);
      #4;
      if (reset === 1'b0 && bus_if.ms_to_ws_valid === 1'b1 && bus_if.ws_allowin === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow: handoff bus %h, nothing expected", bus_if.ms_to_ws_bus);
        end else begin
          exp = sb_q.pop_front();
          chk("ms_to_ws_bus", bus_if.ms_to_ws_bus, exp);
        end
      end
    end
  end

  initial begin
    instr_t t;
    reset = 1'b1;
    bus_if.es_to_ms_valid = 1'b0;
    bus_if.es_to_ms_bus = '0;
    bus_if.ws_allowin = 1'b1;
    bus_if.data_sram_data_ok = 1'b0;
    bus_if.data_sram_rdata = 32'h0;
    occ = 1'b0; occ_mem = 1'b0; occ_load = 1'b0; occ_resp = 1'b0; occ_we = 1'b0;
    occ_dest = 5'd0; occ_res = 32'h0; offer = 1'b0; resp_pend = 1'b0;
    resp_cnt = 0; resp_data = 32'h0; resp_stall = 0; stall_left = 0;
    random_mode = 1'b0; pc_ctr = 32'h1C00_0000;

    rst_req = 1'b1; step(); step();
    rst_req = 1'b0;
    step(); step();                       // post-reset idle state

    // directed cases
    push(mk(1'b0, 3'd0, 1'b0, 1'b1, 5'd5,  32'h0000_1234, 0, 0, 32'h0));
    push(mk(1'b1, 3'd1, 1'b1, 1'b1, 5'd7,  32'h0000_1001, 3, 0, 32'h0000_80FF));
    push(mk(1'b1, 3'd4, 1'b1, 1'b1, 5'd8,  32'h0000_2002, 1, 2, 32'h8001_0000));
    push(mk(1'b0, 3'd0, 1'b1, 1'b0, 5'd9,  32'h0000_3000, 2, 0, 32'hDEAD_BEEF));
    for (int i = 0; i < 4; i++)
      push(mk(1'b0, 3'd0, 1'b0, 1'b1, 5'(10 + i), 32'h0000_4000 + 32'(i), 0, 0, 32'h0));
    push(mk(1'b1, 3'd2, 1'b1, 1'b1, 5'd3,  32'h0000_5003, 0, 0, 32'h1234_F00D));
    push(mk(1'b1, 3'd6, 1'b1, 1'b1, 5'd4,  32'h0000_5001, 2, 0, 32'hCAFE_0123));
    run_until_idle(200);

    // reset while a load waits for its response
    push(mk(1'b1, 3'd0, 1'b1, 1'b1, 5'd6, 32'h0000_6000, 1000, 0, 32'h5555_AAAA));
    for (int i = 0; i < 10 && !occ; i++) step();
    step(); step(); step();
    rst_req = 1'b1; step();
    rst_req = 1'b0;
    step(); step();

    // randomized traffic
    random_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 2))
        0:       t = mk(1'b0, 3'($urandom), 1'b0, 1'($urandom), 5'($urandom), $urandom, 0, 0, $urandom);
        1:       t = mk(1'b1, 3'($urandom), 1'b1, 1'b1, 5'($urandom), $urandom, $urandom_range(0, 4), 0, $urandom);
        default: t = mk(1'b0, 3'($urandom), 1'b1, 1'b0, 5'($urandom), $urandom, $urandom_range(0, 4), 0, $urandom);
      endcase
      push(t);
    end
    run_until_idle(8000);
    step(); step();
    chk("scoreboard_drained", 70'(sb_q.size()), 70'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
